// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller.
// Hits answer in one cycle; misses issue a single word refill, install it and forward it.
module icache_direct #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic        if_fetch_valid,
  input  logic [31:0] if_pc,
  output logic        if_instr_valid,
  output logic [31:0] if_instr,
  output logic        mem_read_signal,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_instr,
  input  logic        mem_success
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                 state, state_n;
  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];

  logic [INDEX_WIDTH-1:0] pend_idx, pend_idx_n, req_idx;
  logic [TAG_W-1:0]       pend_tag, pend_tag_n, req_tag;
  logic                   instr_valid_n, read_n, install, hit;
  logic [31:0]            instr_n, addr_n;
  logic                   unused_pc_bits;

  assign req_idx        = if_pc[INDEX_WIDTH+1:2];
  assign req_tag        = if_pc[31:INDEX_WIDTH+2];
  assign hit            = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign unused_pc_bits = ^if_pc[1:0];

  // NOTE: every variable gets a default before the branches so no path leaves one unassigned (no latches).
  always_comb begin
    state_n       = state;
    instr_valid_n = 1'b0;
    instr_n       = if_instr;
    read_n        = mem_read_signal;
    addr_n        = mem_addr;
    pend_idx_n    = pend_idx;
    pend_tag_n    = pend_tag;
    install       = 1'b0;

    if (jump_wrong) begin
      // Flush drops the refill; a coincident mem_success is neither installed nor forwarded.
      state_n = IDLE;
      read_n  = 1'b0;
      addr_n  = '0;
    end else if (!rdy) begin
      instr_valid_n = if_instr_valid;
    end else begin
      unique case (state)
        IDLE: begin
          if (if_fetch_valid && !if_instr_valid) begin
            if (hit) begin
              instr_valid_n = 1'b1;
              instr_n       = data_mem[req_idx];
            end else begin
              read_n     = 1'b1;
              addr_n     = {if_pc[31:2], 2'b00};
              pend_idx_n = req_idx;
              pend_tag_n = req_tag;
              state_n    = REFILL;
            end
          end
        end
        REFILL: begin
          if (mem_success) begin
            install       = 1'b1;
            instr_valid_n = 1'b1;
            instr_n       = mem_instr;
            read_n        = 1'b0;
            addr_n        = '0;
            state_n       = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      if_instr_valid  <= 1'b0;
      if_instr        <= '0;
      mem_read_signal <= 1'b0;
      mem_addr        <= '0;
      pend_idx        <= '0;
      pend_tag        <= '0;
      valid           <= '0;
    end else begin
      state           <= state_n;
      if_instr_valid  <= instr_valid_n;
      if_instr        <= instr_n;
      mem_read_signal <= read_n;
      mem_addr        <= addr_n;
      pend_idx        <= pend_idx_n;
      pend_tag        <= pend_tag_n;
      if (install) valid[pend_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    if (install) begin
      data_mem[pend_idx] <= mem_instr;
      tag_mem[pend_idx]  <= pend_tag;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Randomised scoreboard bench for icache_direct: a word-address cache model predicts hits,
// misses and returned instructions; a negedge monitor pops and compares each response pulse.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong, if_fetch_valid, mem_success;
  logic [31:0] if_pc, mem_instr;
  logic        if_instr_valid, mem_read_signal;
  logic [31:0] if_instr, mem_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] line_addr [int];
  logic [31:0] line_data [int];
  logic [31:0] mem_img   [logic [31:0]];
  bit          pulse_seen = 1'b0;

  icache_direct #(.INDEX_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .if_fetch_valid(if_fetch_valid), .if_pc(if_pc),
    .if_instr_valid(if_instr_valid), .if_instr(if_instr),
    .mem_read_signal(mem_read_signal), .mem_addr(mem_addr),
    .mem_instr(mem_instr), .mem_success(mem_success)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem_img.exists(a)) mem_img[a] = $urandom;
    return mem_img[a];
  endfunction

  function automatic int index_of(input logic [31:0] a);
    return int'((a >> 2) & 32'hFF);
  endfunction

  // Monitor: one comparison per response pulse (a pulse can be stretched by rdy=0).
  always @(negedge clk) begin
    if (rst) pulse_seen = 1'b0;
    else if (if_instr_valid && !pulse_seen) begin
      pulse_seen = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got instr %h, expected no response", if_instr);
      end else check("instr", if_instr, exp_q.pop_front());
    end else if (!if_instr_valid) pulse_seen = 1'b0;
  end

  // One fetch from IDLE; called at posedge+1 with no pulse visible.
  task automatic do_fetch(input logic [31:0] pc, input bit flush, input int lat);
    logic [31:0] word, data;
    int          idx;
    word = {pc[31:2], 2'b00};
    idx  = index_of(word);
    if_fetch_valid = 1'b1;
    if_pc          = pc;
    if (line_addr.exists(idx) && line_addr[idx] == word) begin
      exp_q.push_back(line_data[idx]);
      @(posedge clk); #1;
      check("hit_no_mem_read", mem_read_signal, 0);
      if_fetch_valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      check("miss_read", mem_read_signal, 1);
      check("miss_addr", mem_addr, word);
      for (int i = 0; i < lat; i++) begin
        @(posedge clk); #1;
        check("refill_hold", {mem_read_signal, mem_addr}, {1'b1, word});
      end
      data        = mem_word(word);
      mem_success = 1'b1;
      mem_instr   = data;
      jump_wrong  = flush;
      if (!flush) exp_q.push_back(data);
      @(posedge clk); #1;
      mem_success    = 1'b0;
      jump_wrong     = 1'b0;
      if_fetch_valid = 1'b0;
      mem_instr      = $urandom;
      check("refill_done_read", mem_read_signal, 0);
      check("refill_done_addr", mem_addr, 0);
      if (flush) check("flush_no_pulse", if_instr_valid, 0);
      else begin
        line_addr[idx] = word;
        line_data[idx] = data;
      end
      @(posedge clk); #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; if_fetch_valid = 1'b0;
    mem_success = 1'b0; if_pc = '0; mem_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_instr_valid", if_instr_valid, 0);
    check("reset_instr", if_instr, 0);
    check("reset_mem_read", mem_read_signal, 0);
    check("reset_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold miss, then hit on the same word.
    mem_img[32'h0] = 32'h0000_0013;
    do_fetch(32'h0000_0000, 1'b0, 2);
    do_fetch(32'h0000_0000, 1'b0, 0);

    // Index aliasing: 0x004 and 0x404 share a line.
    mem_img[32'h004] = 32'hAAAA_0001;
    mem_img[32'h404] = 32'hBBBB_0002;
    do_fetch(32'h0000_0004, 1'b0, 1);
    do_fetch(32'h0000_0404, 1'b0, 3);
    do_fetch(32'h0000_0004, 1'b0, 0);

    // Flush together with mem_success: nothing installed.
    do_fetch(32'h0000_0100, 1'b1, 5);
    do_fetch(32'h0000_0100, 1'b0, 1);

    // Flush and a request in the same cycle: flush wins.
    if_fetch_valid = 1'b1; if_pc = 32'h0; jump_wrong = 1'b1;
    @(posedge clk); #1;
    check("flush_req_no_pulse", if_instr_valid, 0);
    check("flush_req_no_read", mem_read_signal, 0);
    if_fetch_valid = 1'b0; jump_wrong = 1'b0;
    @(posedge clk); #1;
    check("flush_req_still_idle", if_instr_valid, 0);

    // rdy low during a hit pulse freezes it.
    exp_q.push_back(line_data[0]);
    if_fetch_valid = 1'b1; if_pc = 32'h0;
    @(posedge clk); #1;
    check("stall_pulse", if_instr_valid, 1);
    rdy = 1'b0; if_fetch_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_hold_valid", if_instr_valid, 1);
      check("stall_hold_instr", if_instr, 32'h0000_0013);
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    check("stall_release", if_instr_valid, 0);
    check("drain", exp_q.size(), 0);

    // Asynchronous reset in the middle of a refill.
    if_fetch_valid = 1'b1; if_pc = 32'h0000_0200;
    @(posedge clk); #1;
    check("pre_reset_read", mem_read_signal, 1);
    #2 rst = 1'b1; if_fetch_valid = 1'b0;
    #1;
    check("async_reset_read", mem_read_signal, 0);
    check("async_reset_addr", mem_addr, 0);
    check("async_reset_valid", if_instr_valid, 0);
    line_addr.delete();
    line_data.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_fetch(32'h0000_0000, 1'b0, 1);

    // Random traffic over a small, heavily aliased address pool.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) << 28) | ($urandom_range(0, 1) << 10)
         | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      do_fetch(pc, ($urandom_range(0, 7) == 0), $urandom_range(0, 4));
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch unit and the memory controller. It answers fetch requests from its arrays on a hit. On a miss it issues a single 32-bit read to the memory controller's icache port, installs the returned word and forwards it to fetch. A mispredict flush (`jump_wrong`) abandons any outstanding refill. Cache contents survive the flush.

## Interface

Parameters:
- `INDEX_WIDTH`, default 8: line index bits; 2^INDEX_WIDTH lines. Index = `pc[INDEX_WIDTH+1:2]`. Tag = `pc[31:INDEX_WIDTH+2]`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rdy`  in  1  global enable; when low, all state and outputs hold.
- `jump_wrong`  in  1  mispredict flush from ROB.
- `if_fetch_valid`  in  1  fetch request present.
- `if_pc`  in  32  fetch address; bits [1:0] ignored.
- `if_instr_valid`  out  1  one-cycle pulse: `if_instr` is valid for the last accepted request.
- `if_instr`  out  32  fetched instruction.
- `mem_read_signal`  out  1  refill request to memory controller (its `icache_read_signal`).
- `mem_addr`  out  32  refill word address, `{pc[31:2],2'b00}`.
- `mem_instr`  in  32  refill data (controller's `icache_read_instr`).
- `mem_success`  in  1  one-cycle pulse: `mem_instr` valid.

## Operation

Storage:
- `valid[2^INDEX_WIDTH]` is cleared by reset.
- `tag[]` and `data[]` arrays have no reset.

FSM states: IDLE, REFILL. Reset state is IDLE.

Priority on each edge: `rst` (async), then `jump_wrong`, then `rdy` low (hold), then normal operation.

Accepting a request in IDLE:
- A request is accepted when `if_fetch_valid`=1 and `if_instr_valid`=0 in the current cycle.
- Consequence: no request is accepted in the cycle a response pulse is visible. IF changes `if_pc` in that cycle.

Hit (IDLE, `valid[idx]` and `tag[idx]==pc tag`):
- Next edge: `if_instr_valid`←1, `if_instr`←`data[idx]`.
- State stays IDLE.

Miss (IDLE):
- Next edge: `mem_read_signal`←1, `mem_addr`←`{if_pc[31:2],2'b00}`.
- Latch `pend_idx` and `pend_tag`; state←REFILL.

REFILL:
- Hold `mem_read_signal`=1 and `mem_addr` stable until `mem_success`=1.
- On the `mem_success` edge:
  - `data[pend_idx]`←`mem_instr`, `tag[pend_idx]`←`pend_tag`, `valid[pend_idx]`←1.
  - `if_instr_valid`←1, `if_instr`←`mem_instr`.
  - `mem_read_signal`←0, `mem_addr`←0, state←IDLE.
- `if_fetch_valid` and `if_pc` are not sampled in REFILL. IF holds them until the response.

`jump_wrong`=1 (any state):
- Next edge: state←IDLE, `mem_read_signal`←0, `mem_addr`←0, `if_instr_valid`←0.
- A `mem_success` in the same cycle is ignored: no install and no forward.
- The pending refill is dropped. Arrays and `valid` are unchanged.

`rdy`=0:
- Nothing changes, including the `if_instr_valid` pulse, which stays high until `rdy` returns.
- `mem_success` is not sampled while `rdy`=0.

`if_instr_valid` is deasserted on every edge where it is not being set, so it is a one-cycle pulse. `if_instr` holds its last value.

## Timing

Reset values:
- `if_instr_valid`=0, `if_instr`=0.
- `mem_read_signal`=0, `mem_addr`=0.
- State IDLE; all `valid`=0.

Latency:
- Hit: request in cycle N, response in cycle N+1. Peak throughput is one instruction per 2 cycles.
- Miss:
  - Request cycle N.
  - `mem_read_signal` high from N+1.
  - Response in the cycle after `mem_success`, i.e. memory latency + 2.

Handshake:
- Exactly one outstanding refill.
- `mem_read_signal` falls on the edge that samples `mem_success`, so the controller never sees a second request for the same word.

Boundary conditions:
- Index aliasing: two PCs with equal index and different tag evict each other. The latest refill wins.
- A request in the cycle after a refill for the same PC hits.
- `jump_wrong` and a new request in the same cycle: the flush wins and the request is not accepted.

## Test plan

- Reset, then request `pc`=0x00000000 → miss. `mem_read_signal`=1, `mem_addr`=0x0 next cycle. Drive `mem_success` with 0x00000013 → `if_instr_valid` pulse, `if_instr`=0x00000013, `mem_read_signal`=0.
- Re-request 0x00000000 → `if_instr_valid` next cycle with 0x00000013 and no memory request.
- `INDEX_WIDTH`=8: fill 0x00000004 (data 0xAAAA0001), then 0x00000404 (data 0xBBBB0002), same index. Re-fetch 0x00000004 → miss, new refill issued.
- Miss on 0x00000100, hold `mem_success` low 5 cycles, assert `jump_wrong` together with `mem_success` → no `if_instr_valid`. Later fetch of 0x100 misses, proving no install.
- During a hit, drop `rdy` for 3 cycles → `if_instr_valid` stays high and outputs frozen. Raise `rdy` → pulse clears after one more cycle.
- Assert `rst` mid-REFILL, asynchronously between edges → `mem_read_signal`, `if_instr_valid` and `mem_addr` go to 0 immediately. A previously cached PC then misses.
